// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issue / write-back stage in front of a combinational 16-bit ALU.
// It takes one instruction per handshake and reads both operands from an internal 8x16
// register file. Operator and operands are held for the ALU during EXEC. The ALU result is
// captured at the end of EXEC and written back to rd during WB. Each op takes 3 cycles.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   instr/instr_valid instruction in: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2
//   instr_ready       high only in IDLE
//   operator/op1/op2  registered ALU inputs, alu_result is the ALU output
//   ld_en/addr/data   external register load, accepted in any state
//   dbg_addr/dbg_data combinational register file read
//   done, divz_err    one-cycle pulses during WB
module alu_issue_stage #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       REG_AW      = 3,
    parameter logic [DATA_W-1:0] DIVZ_RESULT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [2:0]        operator,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              done,
    output logic              divz_err
);

    localparam int unsigned NumRegs = 1 << REG_AW;
    localparam logic [2:0]  OpDiv   = 3'd4;
    localparam logic [2:0]  OpMod   = 3'd5;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e state_q, state_d;

    logic [NumRegs-1:0][DATA_W-1:0] rf_q, rf_d;
    logic [2:0]                     operator_q, operator_d;
    logic [DATA_W-1:0]              op1_q, op1_d;
    logic [DATA_W-1:0]              op2_q, op2_d;
    logic [REG_AW-1:0]              rd_q, rd_d;
    logic [DATA_W-1:0]              result_q, result_d;
    logic                           divz_q, divz_d;

    // instr[3:0] carries no information for this stage.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[3:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (instr_valid) state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        instr_ready = (state_q == StIdle);
        done        = (state_q == StWb);
        divz_err    = (state_q == StWb) && divz_q;
    end

    assign operator = operator_q;
    assign op1      = op1_q;
    assign op2      = op2_q;
    assign dbg_data = rf_q[dbg_addr];

    // Datapath next-state
    always_comb begin
        rf_d       = rf_q;
        operator_d = operator_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        rd_d       = rd_q;
        result_d   = result_q;
        divz_d     = divz_q;

        if (ld_en) begin
            rf_d[ld_addr] = ld_data;
        end

        unique case (state_q)
            StIdle: begin
                // Operands come from rf_q, so a same-edge load is not bypassed.
                if (instr_valid) begin
                    operator_d = instr[15:13];
                    rd_d       = instr[12:10];
                    op1_d      = rf_q[instr[9:7]];
                    op2_d      = rf_q[instr[6:4]];
                end
            end
            StExec: begin
                divz_d   = ((operator_q == OpDiv) || (operator_q == OpMod)) && (op2_q == '0);
                result_d = divz_d ? DIVZ_RESULT : alu_result;
            end
            StWb: begin
                // Assigned after the load so write-back wins on an address collision.
                rf_d[rd_q] = result_q;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_q       <= '0;
            operator_q <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            rd_q       <= '0;
            result_q   <= '0;
            divz_q     <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            operator_q <= operator_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            divz_q     <= divz_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage.
// A small behavioural ALU closes the loop from operator/op1/op2 to alu_result.
// Inputs are driven and outputs sampled at the falling edge.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  operator;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] alu_result;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        done;
    logic        divz_err;

    int n_cmp = 0;
    int n_err = 0;

    alu_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .operator    (operator),
        .op1         (op1),
        .op2         (op2),
        .alu_result  (alu_result),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .done        (done),
        .divz_err    (divz_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divide by zero returns all ones so a missing DIVZ_RESULT substitution shows up.
    always_comb begin
        alu_result = '0;
        case (operator)
            3'd0: alu_result = op1 + op2;
            3'd1: alu_result = op2 - op1;
            3'd2: alu_result = op1 * op2;
            3'd3: alu_result = ~(op1 & op2);
            3'd4: alu_result = (op2 == 0) ? 16'hFFFF : op1 / op2;
            3'd5: alu_result = (op2 == 0) ? 16'hFFFF : op1 % op2;
            3'd6: alu_result = {15'd0, op1 < op2};
            3'd7: alu_result = {15'd0, op1 <= op2};
            default: alu_result = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check_eq(tag, {16'd0, dbg_data}, {16'd0, exp});
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // ld_mode: 0 none, 1 load on the accept edge, 2 load on the write-back edge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [15:0] e1, input logic [15:0] e2,
                          input logic [15:0] eres, input logic edivz,
                          input int ld_mode, input logic [2:0] ld_a, input logic [15:0] ld_d);
        instr       = {op, rd, rs1, rs2, 4'hA};
        instr_valid = 1'b1;
        check_eq({tag, "/ready_idle"}, {31'd0, instr_ready}, 32'd1);
        if (ld_mode == 1) begin
            ld_en = 1'b1; ld_addr = ld_a; ld_data = ld_d;
        end
        tick();
        instr_valid = 1'b0;
        ld_en       = 1'b0;
        check_eq({tag, "/ready_exec"}, {31'd0, instr_ready}, 32'd0);
        check_eq({tag, "/done_exec"}, {31'd0, done}, 32'd0);
        check_eq({tag, "/operator"}, {29'd0, operator}, {29'd0, op});
        check_eq({tag, "/op1"}, {16'd0, op1}, {16'd0, e1});
        check_eq({tag, "/op2"}, {16'd0, op2}, {16'd0, e2});
        if (ld_mode == 2) begin
            ld_en = 1'b1; ld_addr = ld_a; ld_data = ld_d;
        end
        tick();
        check_eq({tag, "/done_wb"}, {31'd0, done}, 32'd1);
        check_eq({tag, "/divz_wb"}, {31'd0, divz_err}, {31'd0, edivz});
        check_eq({tag, "/ready_wb"}, {31'd0, instr_ready}, 32'd0);
        tick();
        ld_en = 1'b0;
        check_eq({tag, "/done_after"}, {31'd0, done}, 32'd0);
        check_eq({tag, "/divz_after"}, {31'd0, divz_err}, 32'd0);
        check_reg({tag, "/rd"}, rd, eres);
    endtask

    initial begin
        rst         = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        dbg_addr    = '0;
        @(negedge clk);
        tick();

        // Reset state
        check_eq("rst/ready", {31'd0, instr_ready}, 32'd1);
        check_eq("rst/done", {31'd0, done}, 32'd0);
        check_eq("rst/op1", {16'd0, op1}, 32'd0);
        for (int i = 0; i < 8; i++) check_reg("rst/reg", 3'(i), 16'h0);
        rst = 1'b1;
        tick();

        // Reset in the middle of EXEC aborts the instruction
        load(3'd1, 16'd5);
        check_reg("abort/r1_loaded", 3'd1, 16'd5);
        instr       = {3'd0, 3'd1, 3'd1, 3'd1, 4'h0};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check_eq("abort/in_exec", {31'd0, instr_ready}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check_eq("abort/ready", {31'd0, instr_ready}, 32'd1);
        check_eq("abort/op1", {16'd0, op1}, 32'd0);
        check_reg("abort/r1", 3'd1, 16'h0);
        tick();
        check_eq("abort/done0", {31'd0, done}, 32'd0);
        rst = 1'b1;
        tick();
        check_eq("abort/done1", {31'd0, done}, 32'd0);
        tick();
        check_eq("abort/done2", {31'd0, done}, 32'd0);
        check_reg("abort/r1_after", 3'd1, 16'h0);

        // ADD
        load(3'd1, 16'd3);
        load(3'd2, 16'd4);
        run_op("add", 3'd0, 3'd3, 3'd1, 3'd2, 16'd3, 16'd4, 16'd7, 1'b0, 0, 3'd0, 16'd0);

        // SUB computes op2 - op1
        load(3'd1, 16'd2);
        load(3'd2, 16'd9);
        run_op("sub", 3'd1, 3'd4, 3'd1, 3'd2, 16'd2, 16'd9, 16'd7, 1'b0, 0, 3'd0, 16'd0);
        run_op("sub_swap", 3'd1, 3'd4, 3'd2, 3'd1, 16'd9, 16'd2, 16'hFFF9, 1'b0, 0, 3'd0, 16'd0);

        // DIV / MOD by zero and non-zero
        load(3'd1, 16'd10);
        load(3'd2, 16'd0);
        load(3'd5, 16'h1234);
        run_op("divz", 3'd4, 3'd5, 3'd1, 3'd2, 16'd10, 16'd0, 16'h0000, 1'b1, 0, 3'd0, 16'd0);
        load(3'd5, 16'h1234);
        run_op("modz", 3'd5, 3'd5, 3'd1, 3'd2, 16'd10, 16'd0, 16'h0000, 1'b1, 0, 3'd0, 16'd0);
        load(3'd2, 16'd3);
        run_op("div", 3'd4, 3'd5, 3'd1, 3'd2, 16'd10, 16'd3, 16'd3, 1'b0, 0, 3'd0, 16'd0);
        run_op("mod", 3'd5, 3'd6, 3'd1, 3'd2, 16'd10, 16'd3, 16'd1, 1'b0, 0, 3'd0, 16'd0);

        // NAND and LE, with rd == rs1 == rs2 for LE
        load(3'd1, 16'h00FF);
        load(3'd2, 16'h0F0F);
        run_op("nand", 3'd3, 3'd7, 3'd1, 3'd2, 16'h00FF, 16'h0F0F, 16'hFFF0, 1'b0, 0, 3'd0,
               16'd0);
        run_op("le_same", 3'd7, 3'd2, 3'd2, 3'd2, 16'h0F0F, 16'h0F0F, 16'd1, 1'b0, 0, 3'd0,
               16'd0);

        // Write-back versus load collisions
        load(3'd1, 16'd3);
        load(3'd2, 16'd4);
        run_op("coll_same", 3'd0, 3'd3, 3'd1, 3'd2, 16'd3, 16'd4, 16'd7, 1'b0, 2, 3'd3,
               16'hBEEF);
        load(3'd3, 16'd0);
        run_op("coll_diff", 3'd0, 3'd3, 3'd1, 3'd2, 16'd3, 16'd4, 16'd7, 1'b0, 2, 3'd6,
               16'h00AA);
        check_reg("coll_diff/r6", 3'd6, 16'h00AA);

        // Back-to-back with instr_valid held, plus a load of rs1 on the first accept edge
        instr       = {3'd0, 3'd3, 3'd1, 3'd2, 4'h0};
        instr_valid = 1'b1;
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'd100;
        tick();
        ld_en = 1'b0;
        check_eq("b2b/op1_old", {16'd0, op1}, 32'd3);
        check_eq("b2b/ready_exec", {31'd0, instr_ready}, 32'd0);
        instr = {3'd2, 3'd6, 3'd1, 3'd2, 4'h0};
        tick();
        check_eq("b2b/ready_wb", {31'd0, instr_ready}, 32'd0);
        check_eq("b2b/done_wb", {31'd0, done}, 32'd1);
        tick();
        check_eq("b2b/ready_idle", {31'd0, instr_ready}, 32'd1);
        check_eq("b2b/op_held", {29'd0, operator}, 32'd0);
        check_eq("b2b/op1_held", {16'd0, op1}, 32'd3);
        check_reg("b2b/r3", 3'd3, 16'd7);
        tick();
        instr_valid = 1'b0;
        check_eq("b2b/op2nd", {29'd0, operator}, 32'd2);
        check_eq("b2b/op1_new", {16'd0, op1}, 32'd100);
        check_eq("b2b/op2_new", {16'd0, op2}, 32'd4);
        tick();
        check_eq("b2b/done2", {31'd0, done}, 32'd1);
        tick();
        check_reg("b2b/r6", 3'd6, 16'h0190);
        check_eq("b2b/idle_again", {31'd0, instr_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
